// File: rtl/reduction_pkg.sv
// Shared types and constants for the reduction arbiter and its datapath.
package reduction_pkg;

  localparam int RED_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } red_state_t;

  typedef logic [0:0] red_id_t;
  typedef logic [RED_W-1:0] red_data_t;

endpackage

// File: rtl/reduction_unit.sv
// Byte-sum adder tree: adds the byte lanes of two 16-bit operands and
// sign-extends bit 8 of the 10-bit total into the upper byte.
module reduction_unit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] s
);

  logic [8:0] e;
  logic [8:0] f;
  logic [9:0] sum;

  assign e   = {1'b0, a[7:0]} + {1'b0, b[7:0]};
  assign f   = {1'b0, a[15:8]} + {1'b0, b[15:8]};
  assign sum = {1'b0, e} + {1'b0, f};
  assign s   = {{8{sum[8]}}, sum[7:0]};

endmodule

// File: rtl/reduction_arbiter.sv
// Two-requester arbiter that serialises operand pairs through one
// reduction_unit and returns registered results tagged with the requester id.
module reduction_arbiter
  import reduction_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [RED_W-1:0] req0_a,
  input  logic [RED_W-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [RED_W-1:0] req1_a,
  input  logic [RED_W-1:0] req1_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output red_data_t       rsp_data,
  output red_id_t         rsp_id,
  output logic            busy
);

  red_state_t state_r;
  red_state_t state_next_s;
  red_id_t    prio_r;
  red_id_t    id_r;
  red_id_t    gnt_s;
  red_data_t  op_a_r;
  red_data_t  op_b_r;
  red_data_t  sum_s;
  red_data_t  rsp_data_r;
  red_id_t    rsp_id_r;
  logic       rsp_valid_r;
  logic       window_s;
  logic       any_valid_s;
  logic       accept_s;

  reduction_unit u_reduction_unit (
    .a (op_a_r),
    .b (op_b_r),
    .s (sum_s)
  );

  // A lone valid requester wins outright; prio only breaks ties.
  assign any_valid_s = req0_valid | req1_valid;
  assign gnt_s       = (req0_valid && req1_valid) ? prio_r :
                       (req0_valid ? 1'b0 : 1'b1);
  assign accept_s    = window_s & any_valid_s;

  // Grant window: IDLE, or RESP in the cycle the result is consumed.
  always_comb begin
    window_s = 1'b0;
    if (rst) begin
      window_s = 1'b0;
    end else begin
      case (state_r)
        IDLE:    window_s = 1'b1;
        RESP:    window_s = rsp_ready;
        default: window_s = 1'b0;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_next_s = EXEC;
        else          state_next_s = IDLE;
      end
      EXEC: state_next_s = RESP;
      RESP: begin
        if (rsp_ready) state_next_s = any_valid_s ? EXEC : IDLE;
        else           state_next_s = RESP;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Ready outputs: only the granted requester sees ready.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (accept_s) begin
      req0_ready = (gnt_s == 1'b0);
      req1_ready = (gnt_s == 1'b1);
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  // Operand capture, priority update and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_r      <= 1'b0;
      id_r        <= 1'b0;
      op_a_r      <= '0;
      op_b_r      <= '0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      rsp_id_r    <= 1'b0;
    end else begin
      if (accept_s) begin
        id_r   <= gnt_s;
        op_a_r <= gnt_s ? req1_a : req0_a;
        op_b_r <= gnt_s ? req1_b : req0_b;
        prio_r <= (ROUND_ROBIN != 32'sd0) ? ~gnt_s : 1'b0;
      end
      if (state_r == EXEC) begin
        rsp_valid_r <= 1'b1;
        rsp_data_r  <= sum_s;
        rsp_id_r    <= id_r;
      end else if (state_r == RESP && rsp_ready) begin
        rsp_valid_r <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_id    = rsp_id_r;
  assign busy      = (state_r != IDLE);

endmodule
